// File: rtl/ws2812_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// ws2812_frame_ctrl : fetches one frame of GRB pixels, scales by brightness,
//                     streams them to the WS2812 encoder, then runs the latch gap
// Revision 1.0
// =============================================================================
module ws2812_frame_ctrl #(
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_W       = 6,
  parameter int LATCH_CYCLES = 19500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        bright,
  output logic              busy,
  output logic              frame_done,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic [23:0]       enc_rgb,
  output logic              enc_enable,
  input  logic              enc_tx_done
);

  localparam int LCNT_W = $clog2(LATCH_CYCLES + 1);
  localparam int PCNT_W = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [PCNT_W-1:0] LAST_PIX   = PCNT_W'(NUM_LEDS - 1);
  localparam logic [PCNT_W-1:0] NUM_PIX    = PCNT_W'(NUM_LEDS);
  localparam logic [LCNT_W-1:0] LATCH_LAST = LCNT_W'(LATCH_CYCLES - 1);

  logic [2:0]        r_state;
  logic [7:0]        r_bright;
  logic [PCNT_W-1:0] r_pix_cnt;
  logic [LCNT_W-1:0] r_latch_cnt;
  logic [23:0]       r_next_buf;
  logic              r_rd_valid;
  logic [PCNT_W-1:0] w_pix_plus2;

  assign w_pix_plus2 = r_pix_cnt + PCNT_W'(2);

  // (c * (bright + 1)) >> 8 with a 9-bit factor and a 17-bit product
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
    logic [8:0]  f;
    logic [16:0] p;
    f = {1'b0, b} + 9'd1;
    p = {9'b0, c} * {8'b0, f};
    return 8'(p >> 8);
  endfunction

  function automatic logic [23:0] scale_pix(input logic [23:0] px, input logic [7:0] b);
    return {scale_chan(px[23:16], b), scale_chan(px[15:8], b), scale_chan(px[7:0], b)};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bright    <= '0;
      r_pix_cnt   <= '0;
      r_latch_cnt <= '0;
      r_next_buf  <= '0;
      r_rd_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      pix_rd      <= 1'b0;
      pix_addr    <= '0;
      enc_rgb     <= '0;
      enc_enable  <= 1'b0;
    end else begin
      pix_rd     <= 1'b0;
      frame_done <= 1'b0;
      r_rd_valid <= pix_rd;
      case (r_state)
        S_IDLE: begin
          r_pix_cnt   <= '0;
          r_latch_cnt <= '0;
          if (start && !abort) begin
            r_bright <= bright;
            pix_rd   <= 1'b1;
            pix_addr <= '0;
            busy     <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH, S_LOAD, S_SEND: begin
          if (abort) begin
            // The in-flight read, if any, is dropped; the latch gap still runs in full
            enc_enable  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_latch_cnt <= '0;
            r_state     <= S_LATCH;
          end else if (r_state == S_FETCH) begin
            r_state <= S_LOAD;
          end else if (r_state == S_LOAD) begin
            enc_rgb    <= scale_pix(pix_data, r_bright);
            enc_enable <= 1'b1;
            if (NUM_LEDS > 1) begin
              pix_rd   <= 1'b1;
              pix_addr <= ADDR_W'(1);
            end
            r_state <= S_SEND;
          end else begin
            if (r_rd_valid) r_next_buf <= pix_data;
            if (enc_tx_done) begin
              if (r_pix_cnt == LAST_PIX) begin
                enc_enable  <= 1'b0;
                r_latch_cnt <= '0;
                r_state     <= S_LATCH;
              end else begin
                enc_rgb   <= scale_pix(r_next_buf, r_bright);
                r_pix_cnt <= r_pix_cnt + PCNT_W'(1);
                if (w_pix_plus2 < NUM_PIX) begin
                  pix_rd   <= 1'b1;
                  pix_addr <= ADDR_W'(w_pix_plus2);
                end
              end
            end
          end
        end
        S_LATCH: begin
          if (r_latch_cnt == LATCH_LAST) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_latch_cnt <= r_latch_cnt + LCNT_W'(1);
          end
        end
        S_DONE: begin
          r_pix_cnt <= '0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_ws2812_frame_ctrl : frame-level checks with a RAM model and encoder model
// Revision 1.0
// =============================================================================
module tb_ws2812_frame_ctrl;

  localparam int NL   = 3;
  localparam int AW   = 2;
  localparam int LC   = 20;
  localparam int BITP = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    bright = 8'd0;
  logic          busy, frame_done, pix_rd, enc_enable, enc_tx_done;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data = 24'd0;
  logic [23:0]   enc_rgb;
  logic          model_tx = 1'b0;
  logic          force_tx = 1'b0;
  int            enc_cnt = 0;
  logic [23:0]   ram [NL];

  assign enc_tx_done = model_tx | force_tx;

  always #5 clk = ~clk;

  ws2812_frame_ctrl #(.NUM_LEDS(NL), .ADDR_W(AW), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bright(bright),
    .busy(busy), .frame_done(frame_done), .pix_rd(pix_rd), .pix_addr(pix_addr),
    .pix_data(pix_data), .enc_rgb(enc_rgb), .enc_enable(enc_enable),
    .enc_tx_done(enc_tx_done)
  );

  // Synchronous pixel RAM and a fixed-period encoder
  always @(posedge clk) if (pix_rd) pix_data <= ram[pix_addr];

  always @(posedge clk) begin
    if (!enc_enable) begin
      enc_cnt <= 0; model_tx <= 1'b0;
    end else if (enc_cnt == BITP - 1) begin
      enc_cnt <= 0; model_tx <= 1'b1;
    end else begin
      enc_cnt <= enc_cnt + 1; model_tx <= 1'b0;
    end
  end

  logic [23:0] obs_q[$];
  int          rd_q[$];
  int          n = 0, last_hi = 0, done_gap = 0, done_cnt = 0, rise_cnt = 0, fall_cnt = 0;
  logic        en_prev = 1'b0;

  always @(negedge clk) begin
    n++;
    if (enc_enable && enc_tx_done) obs_q.push_back(enc_rgb);
    if (pix_rd) rd_q.push_back(int'(pix_addr));
    if (enc_enable && !en_prev) rise_cnt++;
    if (!enc_enable && en_prev) fall_cnt++;
    en_prev = enc_enable;
    if (enc_enable) last_hi = n;
    if (frame_done) begin done_gap = n - last_hi; done_cnt++; end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: each channel scaled as floor(c*(b+1)/256)
  function automatic logic [23:0] ref_scale(input logic [23:0] px, input int b);
    int g = int'(px[23:16]);
    int r = int'(px[15:8]);
    int l = int'(px[7:0]);
    return {8'((g * (b + 1)) / 256), 8'((r * (b + 1)) / 256), 8'((l * (b + 1)) / 256)};
  endfunction

  typedef struct packed {
    logic [7:0]       br;
    logic [2:0][23:0] px;
    logic [2:0][23:0] ex;
  } vec_t;

  vec_t tbl [4];

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic snapshot(output int r0, output int f0, output int d0);
    @(posedge clk);
    obs_q.delete(); rd_q.delete();
    r0 = rise_cnt; f0 = fall_cnt; d0 = done_cnt;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int r0, f0, d0, lat;
    bit ok;
    for (int i = 0; i < NL; i++) ram[i] = v.px[i];
    bright = v.br;
    snapshot(r0, f0, d0);
    @(negedge clk); start = 1'b1;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk); start = 1'b0; bright = ~v.br; lat++;
      if (enc_enable) break;
    end
    chk({tag, " latency"}, lat, 3);
    wait_done(2000, ok);
    chk({tag, " done seen"}, ok, 1);
    @(negedge clk);
    chk({tag, " words"}, obs_q.size(), NL);
    for (int i = 0; i < NL; i++)
      if (i < obs_q.size()) chk($sformatf("%s word%0d", tag, i), obs_q[i], v.ex[i]);
    chk({tag, " enable rises"}, rise_cnt - r0, 1);
    chk({tag, " enable falls"}, fall_cnt - f0, 1);
    chk({tag, " done count"}, done_cnt - d0, 1);
    chk({tag, " latch gap"}, done_gap, LC + 1);
    chk({tag, " reads"}, rd_q.size(), NL);
    for (int i = 0; i < NL; i++)
      if (i < rd_q.size()) chk($sformatf("%s read%0d", tag, i), rd_q[i], i);
    chk({tag, " busy after"}, busy, 0);
  endtask

  initial begin
    int   r0, f0, d0, cnt;
    bit   ok;
    vec_t v;

    tbl[0].br = 8'd255; tbl[0].px = {24'h0000FF, 24'h00FF00, 24'hFF0000};
    tbl[0].ex = {24'h0000FF, 24'h00FF00, 24'hFF0000};
    tbl[1].br = 8'd127; tbl[1].px = {24'h000000, 24'hFFFFFF, 24'h80FF01};
    tbl[1].ex = {24'h000000, 24'h7F7F7F, 24'h407F00};
    tbl[2].br = 8'd0;   tbl[2].px = {24'hFFFFFF, 24'hABCDEF, 24'h123456};
    tbl[2].ex = {24'h000000, 24'h000000, 24'h000000};
    tbl[3].br = 8'd1;   tbl[3].px = {24'h010203, 24'h808080, 24'hFFFFFF};
    tbl[3].ex = {24'h000000, 24'h010101, 24'h010101};

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset pix_rd", pix_rd, 0);
    chk("reset pix_addr", pix_addr, 0);
    chk("reset enc_rgb", enc_rgb, 0);
    chk("reset enc_enable", enc_enable, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 4; t++) run_frame(tbl[t], $sformatf("tbl%0d", t));

    for (int t = 0; t < 6; t++) begin
      v.br = 8'($urandom_range(0, 255));
      for (int i = 0; i < NL; i++) begin
        v.px[i] = 24'($urandom);
        v.ex[i] = ref_scale(v.px[i], int'(v.br));
      end
      run_frame(v, $sformatf("rnd%0d", t));
    end

    // Second start while busy is neither honoured nor queued
    for (int i = 0; i < NL; i++) ram[i] = tbl[0].px[i];
    bright = 8'd255;
    snapshot(r0, f0, d0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    cnt = 0; ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (frame_done) begin ok = 1'b1; break; end
      if (!busy) cnt++;
    end
    chk("restart done seen", ok, 1);
    chk("restart busy held", cnt, 0);
    repeat (LC + 10) @(negedge clk);
    chk("restart one done", done_cnt - d0, 1);
    chk("restart no requeue", {busy, enc_enable}, 0);

    // Abort during the first pixel, with stray tx_done/abort during the latch gap
    snapshot(r0, f0, d0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10 && !enc_enable; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort enable low", enc_enable, 0);
    repeat (3) @(negedge clk);
    force_tx = 1'b1; abort = 1'b1;
    @(negedge clk); force_tx = 1'b0; abort = 1'b0;
    wait_done(500, ok);
    chk("abort done seen", ok, 1);
    @(negedge clk);
    chk("abort latch gap", done_gap, LC + 1);
    chk("abort reads", rd_q.size(), 2);
    if (rd_q.size() == 2) chk("abort read1 addr", rd_q[1], 1);
    chk("abort words", obs_q.size(), 0);
    chk("abort done count", done_cnt - d0, 1);

    // Asynchronous reset mid-frame
    snapshot(r0, f0, d0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 200 && obs_q.size() < 1; i++) @(negedge clk);
    chk("rst reached pixel1", obs_q.size(), 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst async outputs", {busy, frame_done, pix_rd, pix_addr, enc_rgb, enc_enable}, 0);
    repeat (LC + 30) @(negedge clk);
    chk("rst no done", done_cnt - d0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(tbl[0], "post_rst");

    // start and abort together in IDLE, plus a stray tx_done
    @(negedge clk); start = 1'b1; abort = 1'b1; force_tx = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0; force_tx = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || pix_rd || enc_enable) cnt++;
    end
    chk("start+abort idle", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
